// File: rtl/uarc_console_bridge_pkg.sv
// Shared types for the UARC console bridge: TX FSM states, byte type, console bus indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uarc_console_pkg;

  // Per-channel TX handshake state.
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_WAIT = 2'd1,
    TX_ACK  = 2'd2
  } tx_state_e;

  typedef logic [7:0] byte_t;

  // Conventional bus indices used when the bridge fronts a core's stdio.
  localparam int CONSOLE_STDOUT_CH = 0;
  localparam int CONSOLE_STDIN_CH  = 0;

  // Width of the acknowledge-delay down-counter for a given delay.
  function automatic int ack_cnt_width(input int ack_delay);
    return (ack_delay > 1) ? $clog2(ack_delay) : 1;
  endfunction

endpackage

// File: rtl/uarc_console_bridge_if.sv
// Bundle of core-side UARC handshakes and host-side byte streams for all channels.
// Latency: n/a (wiring only).
// Backpressure: tx_ready/rx_ready per channel, sender_send_acks gate core sends.
interface uarc_console_bridge_if #(
  parameter int WORD_WIDTH = 32,
  parameter int CHANNELS   = 1
);
  // Core side
  logic                                 global_send;
  logic [WORD_WIDTH-1:0]                global_data;
  logic [CHANNELS-1:0]                  sender_enables;
  logic [CHANNELS-1:0]                  sender_send_acks;
  logic [CHANNELS-1:0]                  receiver_sends;
  logic [CHANNELS-1:0][WORD_WIDTH-1:0]  receiver_datas;
  logic [CHANNELS-1:0]                  receiver_send_acks;
  // Host side
  logic [CHANNELS-1:0]                  tx_valid;
  logic [CHANNELS-1:0][7:0]             tx_bytes;
  logic [CHANNELS-1:0]                  tx_ready;
  logic [CHANNELS-1:0]                  rx_valid;
  logic [CHANNELS-1:0][7:0]             rx_bytes;
  logic [CHANNELS-1:0]                  rx_ready;

  // Environment (core + host) view.
  modport master (
    output global_send, global_data, sender_enables, receiver_send_acks,
           tx_ready, rx_valid, rx_bytes,
    input  sender_send_acks, receiver_sends, receiver_datas,
           tx_valid, tx_bytes, rx_ready
  );

  // Bridge view.
  modport slave (
    input  global_send, global_data, sender_enables, receiver_send_acks,
           tx_ready, rx_valid, rx_bytes,
    output sender_send_acks, receiver_sends, receiver_datas,
           tx_valid, tx_bytes, rx_ready
  );
endinterface

// File: rtl/uarc_byte_fifo.sv
// Show-ahead byte FIFO, 2^ADDR_WIDTH entries; ports: push_i/push_dat_i, pop_i, full_o, empty_o, head_o.
// Latency: a push is visible on head_o the cycle after the push edge when the FIFO was empty.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together both succeed.
module uarc_byte_fifo
  import uarc_console_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  byte_t push_dat_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output byte_t head_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  byte_t                 mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  // One extra bit so full and empty are distinct when the pointers coincide.
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally at the power-of-two depth.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; contents are only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/uarc_console_bridge.sv
// Multi-channel console bridge: core UARC sends -> TX byte FIFO, host bytes -> RX FIFO -> core.
// Latency: TX ack ACK_DELAY cycles after acceptance, byte on tx_bytes one cycle later; RX head next cycle.
// Backpressure: full TX FIFO stalls acceptance (no ack); rx_ready drops when RX FIFO is full.
// Ports: clk, reset (async, active low), bus (slave modport carrying all handshakes and byte streams).
module uarc_console_bridge
  import uarc_console_pkg::*;
#(
  parameter int WORD_WIDTH      = 32,
  parameter int CHANNELS        = 1,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int ACK_DELAY       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  uarc_console_bridge_if.slave  bus
);
  localparam int                 CNT_W    = ack_cnt_width(ACK_DELAY);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(ACK_DELAY - 1);

  logic [CHANNELS-1:0]                 ack_vec;
  logic [CHANNELS-1:0]                 rcv_send_vec;
  logic [CHANNELS-1:0][WORD_WIDTH-1:0] rcv_dat_vec;
  logic [CHANNELS-1:0]                 tx_vld_vec;
  logic [CHANNELS-1:0][7:0]            tx_dat_vec;
  logic [CHANNELS-1:0]                 rx_rdy_vec;

  // Only the low byte of the send payload is carried.
  logic unused_data_bits;
  assign unused_data_bits = ^bus.global_data;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel;
    logic               tx_push;
    logic               tx_full, tx_empty;
    logic               rx_full, rx_empty;
    byte_t              tx_head, rx_head;

    assign sel = bus.global_send & bus.sender_enables[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_push = 1'b0;
      case (state_q)
        TX_IDLE: begin
          // Only this FSM pushes, so space seen free here is still free at ACK.
          if (sel && !tx_full) begin
            state_d = TX_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        TX_WAIT: begin
          // Core withdrew or retargeted the send: abandon without pushing.
          if (!sel) begin
            state_d = TX_IDLE;
          end else if (cnt_q == '0) begin
            state_d = TX_ACK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        TX_ACK: begin
          tx_push = 1'b1;
          // Unconditional return to IDLE keeps the still-high send from re-accepting here.
          state_d = TX_IDLE;
        end
        default: state_d = TX_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= TX_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    uarc_byte_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_tx_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (tx_push),
      .push_dat_i (bus.global_data[7:0]),
      .pop_i      (bus.tx_ready[i]),
      .full_o     (tx_full),
      .empty_o    (tx_empty),
      .head_o     (tx_head)
    );

    uarc_byte_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_rx_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (bus.rx_valid[i]),
      .push_dat_i (bus.rx_bytes[i]),
      .pop_i      (bus.receiver_send_acks[i]),
      .full_o     (rx_full),
      .empty_o    (rx_empty),
      .head_o     (rx_head)
    );

    assign ack_vec[i]      = (state_q == TX_ACK);
    assign tx_vld_vec[i]   = ~tx_empty;
    // Heads are masked while empty so uninitialised storage never leaks out.
    assign tx_dat_vec[i]   = tx_empty ? 8'h00 : tx_head;
    assign rx_rdy_vec[i]   = ~rx_full;
    assign rcv_send_vec[i] = ~rx_empty;
    assign rcv_dat_vec[i]  = rx_empty ? '0 : WORD_WIDTH'(rx_head);
  end

  assign bus.sender_send_acks = ack_vec;
  assign bus.receiver_sends   = rcv_send_vec;
  assign bus.receiver_datas   = rcv_dat_vec;
  assign bus.tx_valid         = tx_vld_vec;
  assign bus.tx_bytes         = tx_dat_vec;
  assign bus.rx_ready         = rx_rdy_vec;
endmodule

// File: tb/tb_uarc_console_bridge.sv
// Directed bench for uarc_console_bridge: two channels, 16-deep FIFOs, ACK_DELAY of 4.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at that point.
// Backpressure: exercised through tx_ready held low and rx pushes into a full FIFO.
module tb_uarc_console_bridge;
  localparam int W     = 32;
  localparam int CH    = 2;
  localparam int AW    = 4;
  localparam int AD    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uarc_console_bridge_if #(.WORD_WIDTH(W), .CHANNELS(CH)) bus ();

  uarc_console_bridge #(
    .WORD_WIDTH(W), .CHANNELS(CH), .FIFO_ADDR_WIDTH(AW), .ACK_DELAY(AD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an ack, drop the send, confirm the ack was a single cycle.
  task automatic wait_ack(input string tag, output int lat, output logic [CH-1:0] ackv);
    lat  = -1;
    ackv = '0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (bus.sender_send_acks != '0) begin
        lat  = k;
        ackv = bus.sender_send_acks;
        break;
      end
    end
    bus.global_send    = 1'b0;
    bus.sender_enables = '0;
    tick();
    chk({tag, "_ack_one_cycle"}, 64'(bus.sender_send_acks), 64'(0));
  endtask

  task automatic send_byte(input string tag, input logic [CH-1:0] mask, input logic [7:0] b,
                           output int lat, output logic [CH-1:0] ackv);
    bus.global_data    = {24'h0, b};
    bus.sender_enables = mask;
    bus.global_send    = 1'b1;
    wait_ack(tag, lat, ackv);
  endtask

  // Count acks over a fixed window.
  task automatic count_acks(input int n, output int seen);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bus.sender_send_acks != '0) seen++;
    end
  endtask

  int               lat;
  int               seen;
  logic [CH-1:0]    ackv;
  logic [7:0]       hi_str [3];

  initial begin
    bus.global_send        = 1'b0;
    bus.global_data        = '0;
    bus.sender_enables     = '0;
    bus.receiver_send_acks = '0;
    bus.tx_ready           = '0;
    bus.rx_valid           = '0;
    bus.rx_bytes           = '0;
    hi_str[0] = 8'h48; hi_str[1] = 8'h49; hi_str[2] = 8'h0D;

    // ---- reset state ----
    #12;
    chk("rst_acks",      64'(bus.sender_send_acks), 64'(0));
    chk("rst_rcv_sends", 64'(bus.receiver_sends),   64'(0));
    chk("rst_rcv_datas", 64'(bus.receiver_datas),   64'(0));
    chk("rst_tx_valid",  64'(bus.tx_valid),         64'(0));
    chk("rst_rx_ready",  64'(bus.rx_ready),         64'(2'b11));
    reset = 1'b1;
    tick();

    // ---- single send 0x41 on channel 0 ----
    send_byte("single", 2'b01, 8'h41, lat, ackv);
    chk("single_latency", 64'(lat), 64'(AD));
    chk("single_ack_ch",  64'(ackv), 64'(2'b01));
    chk("single_tx_valid", 64'(bus.tx_valid), 64'(2'b01));
    chk("single_tx_byte", 64'(bus.tx_bytes[0]), 64'(8'h41));
    bus.tx_ready = 2'b01;
    tick();
    bus.tx_ready = 2'b00;
    chk("single_drained", 64'(bus.tx_valid), 64'(0));

    // ---- TX backpressure: 16 sends fill the FIFO, 17th stalls ----
    for (int i = 0; i < DEPTH; i++) begin
      send_byte("fill", 2'b01, 8'(i), lat, ackv);
      chk("fill_latency", 64'(lat), 64'(AD));
    end
    bus.global_data    = 32'h10;
    bus.sender_enables = 2'b01;
    bus.global_send    = 1'b1;
    count_acks(12, seen);
    chk("stall_no_ack", 64'(seen), 64'(0));
    bus.tx_ready = 2'b01;
    tick();
    bus.tx_ready = 2'b00;
    chk("stall_pop_no_ack", 64'(bus.sender_send_acks), 64'(0));
    // FIFO has room from the cycle after the pop; acceptance is the next edge.
    wait_ack("unstall", lat, ackv);
    chk("unstall_latency", 64'(lat), 64'(AD));
    bus.tx_ready = 2'b01;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_byte", 64'(bus.tx_bytes[0]), 64'(i));
      tick();
    end
    bus.tx_ready = 2'b00;
    chk("drain_empty", 64'(bus.tx_valid), 64'(0));

    // ---- kill during WAIT ----
    bus.global_data    = 32'h33;
    bus.sender_enables = 2'b01;
    bus.global_send    = 1'b1;
    tick();  // acceptance edge N
    tick();
    tick();  // now in cycle N+2
    bus.global_send    = 1'b0;
    bus.sender_enables = 2'b00;
    count_acks(10, seen);
    chk("kill_no_ack",   64'(seen), 64'(0));
    chk("kill_tx_empty", 64'(bus.tx_valid), 64'(0));
    send_byte("after_kill", 2'b01, 8'h5A, lat, ackv);
    chk("after_kill_latency", 64'(lat), 64'(AD));
    chk("after_kill_byte", 64'(bus.tx_bytes[0]), 64'(8'h5A));
    bus.tx_ready = 2'b01;
    tick();
    bus.tx_ready = 2'b00;

    // ---- RX "HI\r" on channel 0 ----
    bus.rx_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      bus.rx_bytes[0] = hi_str[i];
      tick();
      if (i == 0) begin
        chk("rx_first_sends", 64'(bus.receiver_sends), 64'(2'b01));
        chk("rx_first_head",  64'(bus.receiver_datas[0]), 64'(32'h48));
      end
    end
    bus.rx_valid = 2'b00;
    bus.receiver_send_acks = 2'b01;
    for (int i = 0; i < 3; i++) begin
      chk("rx_hi_seq", 64'(bus.receiver_datas[0]), 64'(hi_str[i]));
      tick();
    end
    chk("rx_sends_fall", 64'(bus.receiver_sends), 64'(0));
    chk("rx_datas_zero", 64'(bus.receiver_datas[0]), 64'(0));
    tick();  // extra ack on an empty FIFO
    bus.receiver_send_acks = 2'b00;
    chk("rx_extra_ack", 64'(bus.receiver_sends), 64'(0));
    bus.rx_valid    = 2'b01;
    bus.rx_bytes[0] = 8'h55;
    tick();
    bus.rx_valid = 2'b00;
    chk("rx_after_extra_sends", 64'(bus.receiver_sends), 64'(2'b01));
    chk("rx_after_extra_head",  64'(bus.receiver_datas[0]), 64'(32'h55));
    bus.receiver_send_acks = 2'b01;
    tick();
    bus.receiver_send_acks = 2'b00;
    chk("rx_after_extra_pop", 64'(bus.receiver_sends), 64'(0));

    // ---- two channels: simultaneous send, RX fill on channel 1 ----
    send_byte("dual", 2'b11, 8'h77, lat, ackv);
    chk("dual_latency", 64'(lat), 64'(AD));
    chk("dual_ack_both", 64'(ackv), 64'(2'b11));
    chk("dual_tx_valid", 64'(bus.tx_valid), 64'(2'b11));
    chk("dual_tx0", 64'(bus.tx_bytes[0]), 64'(8'h77));
    chk("dual_tx1", 64'(bus.tx_bytes[1]), 64'(8'h77));
    bus.tx_ready = 2'b11;
    tick();
    bus.tx_ready = 2'b00;
    chk("dual_drained", 64'(bus.tx_valid), 64'(0));

    bus.rx_valid = 2'b10;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.rx_bytes[1] = 8'hA0 + 8'(i);
      chk("ch1_rx_ready", 64'(bus.rx_ready[1]), 64'(i < DEPTH));
      tick();
    end
    bus.rx_valid = 2'b00;
    chk("ch0_rx_ready_indep", 64'(bus.rx_ready[0]), 64'(1));
    chk("ch0_rcv_sends_indep", 64'(bus.receiver_sends[0]), 64'(0));
    chk("ch1_rcv_sends", 64'(bus.receiver_sends[1]), 64'(1));
    bus.receiver_send_acks = 2'b10;
    for (int i = 0; i < DEPTH; i++) begin
      chk("ch1_drain", 64'(bus.receiver_datas[1]), 64'(8'hA0 + 8'(i)));
      tick();
    end
    bus.receiver_send_acks = 2'b00;
    chk("ch1_drained", 64'(bus.receiver_sends[1]), 64'(0));
    chk("ch1_ready_back", 64'(bus.rx_ready[1]), 64'(1));
    // Pointers have wrapped back to slot 0.
    bus.rx_valid = 2'b10;
    bus.rx_bytes[1] = 8'hC1;
    tick();
    bus.rx_bytes[1] = 8'hC2;
    tick();
    bus.rx_valid = 2'b00;
    bus.receiver_send_acks = 2'b10;
    chk("wrap_head0", 64'(bus.receiver_datas[1]), 64'(8'hC1));
    tick();
    chk("wrap_head1", 64'(bus.receiver_datas[1]), 64'(8'hC2));
    tick();
    bus.receiver_send_acks = 2'b00;
    chk("wrap_empty", 64'(bus.receiver_sends[1]), 64'(0));

    // ---- asynchronous reset during WAIT with a full RX FIFO ----
    bus.rx_valid = 2'b10;
    for (int i = 0; i < DEPTH; i++) begin
      bus.rx_bytes[1] = 8'(i);
      tick();
    end
    bus.rx_valid = 2'b00;
    chk("pre_rst_full", 64'(bus.rx_ready), 64'(2'b01));
    bus.global_data    = 32'h99;
    bus.sender_enables = 2'b01;
    bus.global_send    = 1'b1;
    tick();
    tick();  // FSM in WAIT
    #2;
    reset = 1'b0;
    #1;
    chk("arst_acks",      64'(bus.sender_send_acks), 64'(0));
    chk("arst_rcv_sends", 64'(bus.receiver_sends),   64'(0));
    chk("arst_rcv_datas", 64'(bus.receiver_datas),   64'(0));
    chk("arst_tx_valid",  64'(bus.tx_valid),         64'(0));
    chk("arst_rx_ready",  64'(bus.rx_ready),         64'(2'b11));
    bus.global_send    = 1'b0;
    bus.sender_enables = 2'b00;
    tick();
    #2;
    reset = 1'b1;
    count_acks(10, seen);
    chk("post_rst_no_ack",   64'(seen), 64'(0));
    chk("post_rst_tx_empty", 64'(bus.tx_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uarc_console_bridge.md
# uarc_console_bridge

Synthesizable multi-channel byte console bridge between a core's UARC bus handshakes and host-side byte streams (UART, JTAG mailbox or bench). Each channel maps one UARC bus to a TX byte FIFO fed from core sends and an RX byte FIFO fed to the core as receiver sends. A programmable acknowledge latency models slow peripherals. The bridge sits beside a core0 instance at top level and replaces hand-written stdin/stdout harness logic.

## Interface
- `WORD_WIDTH`, 32: UARC data word width; must be at least 8.
- `CHANNELS`, 1: number of bridged buses, 1..32.
- `FIFO_ADDR_WIDTH`, 4: each FIFO holds 2^FIFO_ADDR_WIDTH bytes.
- `ACK_DELAY`, 4: cycles from TX acceptance to `sender_send_acks` pulse; must be at least 1.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `global_send` in 1: core send request, shared by all buses.
- `global_data` in WORD_WIDTH: core send payload; bits [7:0] are used.
- `sender_enables` in CHANNELS: bus select for the current send.
- `sender_send_acks` out CHANNELS: one-cycle send acknowledge per channel.
- `receiver_sends` out CHANNELS: RX byte available for the core.
- `receiver_datas` out CHANNELS×WORD_WIDTH: zero-extended RX FIFO head.
- `receiver_send_acks` in CHANNELS: core consumed the RX word.
- `tx_valid` out CHANNELS: TX FIFO non-empty.
- `tx_bytes` out CHANNELS×8: TX FIFO head.
- `tx_ready` in CHANNELS: host pops the TX head.
- `rx_valid` in CHANNELS: host offers a byte.
- `rx_bytes` in CHANNELS×8: host byte.
- `rx_ready` out CHANNELS: RX FIFO not full.

## Operation
- Reset values: all FIFOs empty, all TX FSMs in IDLE, delay counters 0. `sender_send_acks`, `receiver_sends`, `tx_valid` = 0. `receiver_datas` = 0. `rx_ready` = all ones.
- Per-channel TX FSM:
  - IDLE → WAIT when `global_send & sender_enables[i]` and the TX FIFO is not full. Counter loads ACK_DELAY−1.
  - IDLE holds while that FIFO is full. This is backpressure: no ack is issued and no byte is lost.
  - WAIT decrements the counter. At 0 it goes to ACK.
  - WAIT → IDLE with no push if `global_send` or `sender_enables[i]` drops. This covers a kill or retarget.
  - ACK: `sender_send_acks[i]` = 1 for exactly this cycle. `global_data[7:0]` is pushed into the TX FIFO this cycle, then the FSM returns to IDLE.
  - The FSM must not re-accept in the cycle after ACK. The core drops send after seeing the ack.
- Space reserved at acceptance is guaranteed: only this FSM pushes the TX FIFO.
- Multiple enable bits set: each channel runs independently. All enabled channels capture the same byte.
- RX path:
  - `rx_ready[i]` = !full. The host push occurs when `rx_valid & rx_ready`.
  - `receiver_sends[i]` = !empty. `receiver_datas[i]` = {zeros, head}.
  - Pop when `receiver_send_acks[i]` is high and the FIFO is not empty. An ack on an empty FIFO is ignored.
- TX host side: pop when `tx_valid & tx_ready`.
- Push and pop in the same cycle on a non-full, non-empty FIFO: occupancy unchanged, both succeed. Pointers wrap modulo 2^FIFO_ADDR_WIDTH. A separate count of width FIFO_ADDR_WIDTH+1 distinguishes full from empty.
- Reset asserted mid-operation clears everything immediately. An in-flight TX byte is discarded and never acked.

## Timing
- TX: acceptance at edge N, ack high during cycle N+ACK_DELAY, byte visible on `tx_bytes` from cycle N+ACK_DELAY+1.
- RX: push at edge N, `receiver_sends` high from cycle N+1 when the FIFO was empty. After an ack-pop at edge M, the next head appears in cycle M+1.
- All outputs are registered or decoded only from registered FIFO state. There are no combinational paths from inputs to outputs.
- Sustained throughput: one TX byte per ACK_DELAY+2 cycles per channel. RX and host-side TX run at one byte per cycle.

## Structure
- Package `uarc_console_pkg`: TX FSM state enum (IDLE, WAIT, ACK), byte typedef, and helper constants for stdin/stdout bus indices.
- Sub-module `uarc_byte_fifo`: parametrised on FIFO_ADDR_WIDTH, show-ahead, with push/pop/full/empty/head. It is instantiated twice per channel in a generate loop.
- The top level contains the generate loop, the TX FSMs and counters, and zero-extension.

## Test plan
- Single send, ACK_DELAY=4: core sends 0x41 on channel 0 → ack in exactly cycle N+4 for one cycle, then `tx_bytes`=0x41 with `tx_valid`.
- TX backpressure, FIFO depth 16, `tx_ready`=0: 17 sends → 16 acks, the 17th stalls in IDLE. One host pop → the 17th is acked ACK_DELAY cycles later.
- Kill during WAIT: `global_send` drops at cycle N+2 → no ack, TX FIFO stays empty, and the next send is accepted normally.
- RX stream "HI\r" with the core acking each cycle → `receiver_datas` 0x48, 0x49, 0x0D in order. `receiver_sends` falls the cycle after the last pop. An extra ack is ignored.
- CHANNELS=2, sends on both buses simultaneously, 17 RX bytes into channel 1 with no core acks → TX and RX remain independent per channel. Channel 1 `rx_ready` drops at 16 bytes and pointers wrap correctly after draining.
- Reset low during WAIT and with full FIFOs → all outputs return to reset values asynchronously, and no ack appears after release.
